pll_phase_sequencer: RTL and testbench

PLL_PHASE_SEQUENCER -- requirements
Module: pll_phase_sequencer

---
 rtl/pll_phase_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_pll_phase_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_phase_sequencer.sv
// Dynamic fine-phase sequencer for a multi-output PLL: debounces lock, issues
// timed phasestep pulses per request, tracks per-channel phase and recovers from lock loss.
module pll_phase_sequencer #(
    parameter int CHANNELS     = 4,
    parameter int STEP_W       = 8,
    parameter int PHASE_MOD    = 64,
    parameter int SETUP_CYC    = 2,
    parameter int PULSE_CYC    = 2,
    parameter int SETTLE_CYC   = 8,
    parameter int LOCK_FILT    = 16,
    parameter int RST_CYC      = 16,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                                    clk_i,
    input  logic                                    reset,
    input  logic                                    req_valid,
    output logic                                    req_ready,
    input  logic [1:0]                              req_ch,
    input  logic [STEP_W-1:0]                       req_steps,
    input  logic                                    pll_locked,
    output logic                                    pll_reset,
    output logic [1:0]                              phasesel,
    output logic                                    phasedir,
    output logic                                    phasestep,
    output logic                                    phaseloadreg,
    output logic                                    done,
    output logic                                    err,
    output logic                                    fault,
    output logic                                    locked_o,
    output logic [7:0]                              relock_cnt,
    output logic [CHANNELS*$clog2(PHASE_MOD)-1:0]   phase_pos
);

    localparam int POS_W   = $clog2(PHASE_MOD);
    localparam int FILT_W  = $clog2(LOCK_FILT + 1);
    localparam int TO_W    = $clog2(LOCK_TIMEOUT + 1);
    localparam int MAX_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_B   = (MAX_A > SETTLE_CYC) ? MAX_A : SETTLE_CYC;
    localparam int CYC_MAX = (MAX_B > RST_CYC) ? MAX_B : RST_CYC;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);

    typedef enum logic [2:0] {
        WAIT_LOCK,
        IDLE,
        SETUP,
        PULSE,
        GAP,
        PLLRST
    } state_t;

    state_t              state_reg, state_next;
    logic [CYC_W-1:0]    cyc_cnt_reg, cyc_cnt_next;
    logic [TO_W-1:0]     wait_cnt_reg, wait_cnt_next;
    logic [STEP_W-1:0]   steps_left_reg, steps_left_next;
    logic [1:0]          ch_reg, ch_next;
    logic                dir_reg, dir_next;
    logic                done_reg, done_next;
    logic                err_reg, err_next;
    logic                fault_reg, fault_next;
    logic [7:0]          relock_cnt_reg, relock_cnt_next;
    logic [FILT_W-1:0]   filt_cnt_reg;
    logic                lock_filt_reg, lock_filt_next;
    logic                pos_step, pos_clear;
    logic                accept, bad_ch, lock_lost, in_flight;
    logic [STEP_W-1:0]   req_mag;

    // Lock debounce: locked_o is the registered filter gated by the raw lock,
    // so it drops in the very cycle the PLL reports loss of lock.
    assign lock_filt_next = pll_locked &&
                            (lock_filt_reg || (filt_cnt_reg == FILT_W'(LOCK_FILT - 1)));

    always_ff @(posedge clk_i) begin
        if (reset || !pll_locked) begin
            filt_cnt_reg  <= '0;
            lock_filt_reg <= 1'b0;
        end else begin
            lock_filt_reg <= lock_filt_next;
            if (!lock_filt_next)
                filt_cnt_reg <= filt_cnt_reg + FILT_W'(1);
        end
    end

    assign locked_o = lock_filt_reg & pll_locked;

    assign req_ready = (state_reg == IDLE) && locked_o;
    assign accept    = req_valid && req_ready;
    assign bad_ch    = ({1'b0, req_ch} >= 3'(CHANNELS));
    // Two's-complement magnitude kept unsigned, so the most negative value maps to 2^(STEP_W-1).
    assign req_mag   = req_steps[STEP_W-1] ? ((~req_steps) + STEP_W'(1)) : req_steps;
    assign in_flight = (state_reg == SETUP) || (state_reg == PULSE) || (state_reg == GAP);
    assign lock_lost = !locked_o && (in_flight || (state_reg == IDLE));

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_reg      <= WAIT_LOCK;
            cyc_cnt_reg    <= '0;
            wait_cnt_reg   <= '0;
            steps_left_reg <= '0;
            ch_reg         <= '0;
            dir_reg        <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            fault_reg      <= 1'b0;
            relock_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            cyc_cnt_reg    <= cyc_cnt_next;
            wait_cnt_reg   <= wait_cnt_next;
            steps_left_reg <= steps_left_next;
            ch_reg         <= ch_next;
            dir_reg        <= dir_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
            fault_reg      <= fault_next;
            relock_cnt_reg <= relock_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cyc_cnt_next    = cyc_cnt_reg;
        wait_cnt_next   = wait_cnt_reg;
        steps_left_next = steps_left_reg;
        ch_next         = ch_reg;
        dir_next        = dir_reg;
        fault_next      = fault_reg;
        relock_cnt_next = relock_cnt_reg;
        done_next       = 1'b0;
        err_next        = 1'b0;
        pos_step        = 1'b0;
        pos_clear       = 1'b0;

        case (state_reg)
            WAIT_LOCK: begin
                // Leave on the edge the filter qualifies, so IDLE coincides with locked_o rising.
                if (lock_filt_next) begin
                    state_next = IDLE;
                    fault_next = 1'b0;
                end else if (wait_cnt_reg == TO_W'(LOCK_TIMEOUT - 1)) begin
                    fault_next   = 1'b1;
                    state_next   = PLLRST;
                    cyc_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt_reg + TO_W'(1);
                end
            end
            IDLE: begin
                if (accept) begin
                    if (bad_ch) begin
                        err_next = 1'b1;
                    end else if (req_mag == '0) begin
                        done_next = 1'b1;
                    end else begin
                        ch_next         = req_ch;
                        dir_next        = req_steps[STEP_W-1];
                        steps_left_next = req_mag;
                        cyc_cnt_next    = '0;
                        state_next      = SETUP;
                    end
                end
            end
            SETUP: begin
                if (cyc_cnt_reg == CYC_W'(SETUP_CYC - 1)) begin
                    cyc_cnt_next = '0;
                    state_next   = PULSE;
                end else begin
                    cyc_cnt_next = cyc_cnt_reg + CYC_W'(1);
                end
            end
            PULSE: begin
                if (cyc_cnt_reg == CYC_W'(PULSE_CYC - 1)) begin
                    pos_step     = 1'b1;
                    cyc_cnt_next = '0;
                    state_next   = GAP;
                end else begin
                    cyc_cnt_next = cyc_cnt_reg + CYC_W'(1);
                end
            end
            GAP: begin
                if (cyc_cnt_reg == CYC_W'(SETTLE_CYC - 1)) begin
                    cyc_cnt_next = '0;
                    if (steps_left_reg == STEP_W'(1)) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        steps_left_next = steps_left_reg - STEP_W'(1);
                        state_next      = SETUP;
                    end
                end else begin
                    cyc_cnt_next = cyc_cnt_reg + CYC_W'(1);
                end
            end
            PLLRST: begin
                if (cyc_cnt_reg == CYC_W'(RST_CYC - 1)) begin
                    pos_clear     = 1'b1;
                    wait_cnt_next = '0;
                    cyc_cnt_next  = '0;
                    state_next    = WAIT_LOCK;
                end else begin
                    cyc_cnt_next = cyc_cnt_reg + CYC_W'(1);
                end
            end
            default: state_next = WAIT_LOCK;
        endcase

        // Lock loss overrides whatever the step sequence wanted this cycle.
        if (lock_lost) begin
            state_next   = PLLRST;
            cyc_cnt_next = '0;
            done_next    = 1'b0;
            err_next     = in_flight;
            pos_step     = 1'b0;
            if (relock_cnt_reg != 8'hFF)
                relock_cnt_next = relock_cnt_reg + 8'd1;
        end
    end

    logic [POS_W-1:0] pos_reg [CHANNELS];

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_pos
            always_ff @(posedge clk_i) begin
                if (reset || pos_clear) begin
                    pos_reg[gi] <= '0;
                end else if (pos_step && (ch_reg == 2'(gi))) begin
                    if (dir_reg)
                        pos_reg[gi] <= (pos_reg[gi] == '0) ? POS_W'(PHASE_MOD - 1)
                                                          : pos_reg[gi] - POS_W'(1);
                    else
                        pos_reg[gi] <= (pos_reg[gi] == POS_W'(PHASE_MOD - 1)) ? '0
                                                          : pos_reg[gi] + POS_W'(1);
                end
            end
            assign phase_pos[gi*POS_W +: POS_W] = pos_reg[gi];
        end
    endgenerate

    // phasestep is gated combinationally so lock loss or reset kills the pulse immediately.
    assign phasestep    = (state_reg == PULSE) && locked_o && !reset;
    assign pll_reset    = (state_reg == PLLRST);
    assign phaseloadreg = 1'b0;
    assign phasesel     = ch_reg;
    assign phasedir     = dir_reg;
    assign done         = done_reg;
    assign err          = err_reg;
    assign fault        = fault_reg;
    assign relock_cnt   = relock_cnt_reg;

endmodule

// File: tb/tb_pll_phase_sequencer.sv
// Scoreboard bench for pll_phase_sequencer: directed requests push expected
// done/err and phasestep events; negedge monitors pop and compare them.
module tb_pll_phase_sequencer;

    localparam int CH     = 2;
    localparam int STEP_W = 8;
    localparam int POS_W  = 6;
    localparam int P      = 12;

    logic                  clk_i = 1'b0;
    logic                  reset = 1'b1;
    logic                  req_valid = 1'b0;
    logic                  req_ready;
    logic [1:0]            req_ch = 2'd0;
    logic [STEP_W-1:0]     req_steps = '0;
    logic                  pll_locked = 1'b0;
    logic                  pll_reset;
    logic [1:0]            phasesel;
    logic                  phasedir, phasestep, phaseloadreg;
    logic                  done, err, fault, locked_o;
    logic [7:0]            relock_cnt;
    logic [CH*POS_W-1:0]   phase_pos;

    pll_phase_sequencer #(
        .CHANNELS(CH), .STEP_W(STEP_W), .PHASE_MOD(64), .SETUP_CYC(2), .PULSE_CYC(2),
        .SETTLE_CYC(8), .LOCK_FILT(16), .RST_CYC(16), .LOCK_TIMEOUT(100)
    ) dut (
        .clk_i(clk_i), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_ch(req_ch), .req_steps(req_steps), .pll_locked(pll_locked),
        .pll_reset(pll_reset), .phasesel(phasesel), .phasedir(phasedir),
        .phasestep(phasestep), .phaseloadreg(phaseloadreg), .done(done), .err(err),
        .fault(fault), .locked_o(locked_o), .relock_cnt(relock_cnt), .phase_pos(phase_pos)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct { bit is_err; int cyc; logic [CH*POS_W-1:0] pos; } resp_t;
    typedef struct { int cyc; logic [1:0] sel; bit dir; } step_t;
    resp_t resp_q[$];
    step_t step_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s = %0d (cycle %0d)", name, act, cyc);
        end
    endtask

    always @(negedge clk_i) begin : mon
        resp_t r;
        step_t s;
        if (!reset) begin
            if (done || err) begin
                if (resp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_resp: done=%0b err=%0b at cycle %0d, none expected",
                             done, err, cyc);
                end else begin
                    r = resp_q.pop_front();
                    check("resp_is_err", 64'(err), 64'(r.is_err));
                    check("resp_cycle", 64'(cyc), 64'(r.cyc));
                    check("resp_phase_pos", 64'(phase_pos), 64'(r.pos));
                    check("done_err_exclusive", 64'(done & err), 64'd0);
                end
            end
            if (phasestep) begin
                if (step_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_phasestep: got 1 expected 0 at cycle %0d", cyc);
                end else begin
                    s = step_q.pop_front();
                    check("step_cycle", 64'(cyc), 64'(s.cyc));
                    check("step_phasesel", 64'(phasesel), 64'(s.sel));
                    check("step_phasedir", 64'(phasedir), 64'(s.dir));
                end
            end
        end
    end

    // Presents one request when req_ready is high; lat<0 means no done/err is queued.
    task automatic issue(input logic [1:0] ch, input logic [STEP_W-1:0] steps,
                         input bit is_err, input int lat, input logic [CH*POS_W-1:0] pos,
                         input int nsteps, input bit dir, output int t);
        resp_t r;
        step_t s;
        int budget;
        budget = 0;
        while (!req_ready && budget < 200) begin
            @(posedge clk_i); #1;
            budget++;
        end
        if (!req_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL req_ready_timeout: got 0 expected 1 within 200 cycles");
        end
        req_valid = 1'b1;
        req_ch    = ch;
        req_steps = steps;
        t = cyc;
        if (lat >= 0) begin
            r.is_err = is_err; r.cyc = t + lat; r.pos = pos;
            resp_q.push_back(r);
        end
        for (int k = 0; k < nsteps; k++) begin
            s.sel = ch; s.dir = dir;
            s.cyc = t + 3 + k*P; step_q.push_back(s);
            s.cyc = t + 4 + k*P; step_q.push_back(s);
        end
        $display("req ch=%0d steps=%0d accepted-cycle=%0d", ch, $signed(steps), t);
        @(posedge clk_i); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((resp_q.size() != 0 || step_q.size() != 0) && n < budget) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (resp_q.size() != 0 || step_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0",
                     resp_q.size(), step_q.size());
        end
    endtask

    task automatic pulse_len(output int len);
        len = 0;
        while (pll_reset && len < 50) begin
            len++;
            @(posedge clk_i); #1;
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t, len, gap;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_pll_reset", 64'(pll_reset), 64'd0);
        check("rst_phasestep", 64'(phasestep), 64'd0);
        check("rst_phasedir", 64'(phasedir), 64'd0);
        check("rst_phasesel", 64'(phasesel), 64'd0);
        check("rst_phaseloadreg", 64'(phaseloadreg), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_done_err", 64'({done, err}), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);
        check("rst_locked_o", 64'(locked_o), 64'd0);
        check("rst_phase_pos", 64'(phase_pos), 64'd0);
        check("rst_relock_cnt", 64'(relock_cnt), 64'd0);

        // Relock timeout with the PLL never locking.
        reset = 1'b0;
        repeat (99) @(posedge clk_i);
        #1;
        check("timeout_fault_before", 64'(fault), 64'd0);
        @(posedge clk_i); #1;
        check("timeout_fault_set", 64'(fault), 64'd1);
        check("timeout_pll_reset", 64'(pll_reset), 64'd1);
        pulse_len(len);
        check("timeout_rst_len1", 64'(len), 64'd16);
        gap = 0;
        while (!pll_reset && gap < 200) begin
            gap++;
            @(posedge clk_i); #1;
        end
        check("timeout_retry_gap", 64'(gap), 64'd100);
        check("timeout_fault_held", 64'(fault), 64'd1);
        pulse_len(len);
        check("timeout_rst_len2", 64'(len), 64'd16);
        pll_locked = 1'b1;
        repeat (15) @(posedge clk_i);
        #1;
        check("relock_fault_still", 64'(fault), 64'd1);
        check("relock_locked_early", 64'(locked_o), 64'd0);
        @(posedge clk_i); #1;
        check("relock_fault_clear", 64'(fault), 64'd0);
        check("relock_locked_o", 64'(locked_o), 64'd1);
        check("relock_cnt_no_loss", 64'(relock_cnt), 64'd0);

        // Debounce from reset release with lock held high.
        reset = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        reset = 1'b0;
        repeat (15) @(posedge clk_i);
        #1;
        check("deb_locked_15", 64'(locked_o), 64'd0);
        check("deb_ready_15", 64'(req_ready), 64'd0);
        @(posedge clk_i); #1;
        check("deb_locked_16", 64'(locked_o), 64'd1);
        check("deb_ready_16", 64'(req_ready), 64'd1);

        // Directed requests: {pos1,pos0} expected at the done/err cycle.
        issue(2'd1, 8'sd3,  1'b0, 37,   {6'd3, 6'd0},  3,   1'b0, t); drain(100);
        issue(2'd0, -8'sd1, 1'b0, 13,   {6'd3, 6'd63}, 1,   1'b1, t); drain(100);
        issue(2'd0, 8'sd0,  1'b0, 1,    {6'd3, 6'd63}, 0,   1'b0, t); drain(100);
        issue(2'd3, 8'sd5,  1'b1, 1,    {6'd3, 6'd63}, 0,   1'b0, t); drain(100);
        issue(2'd0, 8'sd2,  1'b0, 25,   {6'd3, 6'd1},  2,   1'b0, t); drain(100);
        issue(2'd1, 8'h80,  1'b0, 1537, {6'd3, 6'd1},  128, 1'b1, t); drain(1700);

        // Lock loss during the second PULSE of a 5-step request.
        issue(2'd1, 8'sd5, 1'b0, -1, '0, 1, 1'b0, t);
        resp_q.push_back('{is_err: 1'b1, cyc: t + 16, pos: {6'd4, 6'd1}});
        repeat (14) @(posedge clk_i);
        #1;
        check("loss_step_high", 64'(phasestep), 64'd1);
        pll_locked = 1'b0;
        #1;
        check("loss_step_dropped", 64'(phasestep), 64'd0);
        check("loss_locked_o", 64'(locked_o), 64'd0);
        @(posedge clk_i); #1;
        check("loss_relock_cnt", 64'(relock_cnt), 64'd1);
        check("loss_pll_reset_start", 64'(pll_reset), 64'd1);
        pulse_len(len);
        check("loss_rst_len", 64'(len), 64'd16);
        check("loss_phase_pos_zero", 64'(phase_pos), 64'd0);
        pll_locked = 1'b1;
        drain(100);
        len = 0;
        while (!req_ready && len < 100) begin
            @(posedge clk_i); #1;
            len++;
        end
        check("loss_ready_again", 64'(req_ready), 64'd1);
        check("end_phaseloadreg", 64'(phaseloadreg), 64'd0);
        check("end_resp_q_empty", 64'(resp_q.size()), 64'd0);
        check("end_step_q_empty", 64'(step_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
